// File: rtl/gauss_blur_nch.sv
// Multi-channel separable binomial blur with edge replication and rounding.
// Optional assertions: define GAUSS_BLUR_NCH_SVA_EN.
module gauss_blur_nch #(
    parameter int COLORDEPTH = 8,
    parameter int M_DEPTH    = 5,
    parameter int CHANNELS   = 3
) (
    input  logic                                     clk,
    input  logic                                     rst,
    input  logic [CHANNELS*M_DEPTH*COLORDEPTH-1:0]   vect_in,
    input  logic                                     dv_i,
    input  logic                                     hs_i,
    input  logic                                     vs_i,
    input  logic                                     mode_i,
    output logic [CHANNELS*COLORDEPTH-1:0]           conv_o,
    output logic                                     dv_o,
    output logic                                     hs_o,
    output logic                                     vs_o,
    output logic                                     line_end_o
);

    localparam int H     = (M_DEPTH - 1) / 2;
    localparam int LAT   = H + 3;
    localparam int VW    = COLORDEPTH + M_DEPTH - 1;
    localparam int SHIFT = 2 * (M_DEPTH - 1);
    localparam int SW    = COLORDEPTH + SHIFT;
    localparam int CW    = $clog2(H + 1);
    localparam logic [SW:0]           RND  = (SW + 1)'(1) << (SHIFT - 1);
    localparam logic [COLORDEPTH-1:0] PMAX = '1;

    function automatic int binom(input int n, input int k);
        int c;
        c = 1;
        for (int i = 0; i < k; i++) c = c * (n - i) / (i + 1);
        return c;
    endfunction

    logic [LAT:1]                  dv_d, hs_d, vs_d;
    logic                          mode_q;
    logic [CW-1:0]                 flush_q, flush_d, cnt_eff;
    logic                          rise, fall, shift_en;
    logic [VW-1:0]                 v_in    [CHANNELS];
    logic [COLORDEPTH-1:0]         pix_mid [CHANNELS];
    logic [VW-1:0]                 win_q   [CHANNELS][M_DEPTH];
    logic [COLORDEPTH-1:0]         ctr_q   [CHANNELS][H+1];
    logic [SW-1:0]                 s_d     [CHANNELS];
    logic [SW-1:0]                 s_q     [CHANNELS];
    logic [COLORDEPTH-1:0]         byp_q   [CHANNELS];
    logic [SW:0]                   rnd     [CHANNELS];
    logic [CHANNELS*COLORDEPTH-1:0] conv_d, conv_q;

    // A falling dv_i counts as the first flush step, so the counter left in
    // flush_q only covers the remaining H-1 replications.
    always_comb begin
        rise     = dv_i & ~dv_d[1];
        fall     = ~dv_i & dv_d[1];
        cnt_eff  = fall ? CW'(H) : flush_q;
        shift_en = dv_i | (cnt_eff != '0);
        flush_d  = (!dv_i && cnt_eff != '0) ? cnt_eff - CW'(1) : '0;
    end

    always_comb begin
        for (int c = 0; c < CHANNELS; c++) begin
            v_in[c]    = '0;
            pix_mid[c] = vect_in[(c*M_DEPTH+H)*COLORDEPTH +: COLORDEPTH];
            for (int r = 0; r < M_DEPTH; r++)
                v_in[c] = v_in[c] + VW'(binom(M_DEPTH - 1, r))
                                  * VW'(vect_in[(c*M_DEPTH+r)*COLORDEPTH +: COLORDEPTH]);
        end
    end

    // NOTE: every combinational output gets a default before the loops so no latch is inferred.
    always_comb begin
        conv_d = '0;
        for (int c = 0; c < CHANNELS; c++) begin
            s_d[c] = '0;
            for (int k = 0; k < M_DEPTH; k++)
                s_d[c] = s_d[c] + SW'(binom(M_DEPTH - 1, k)) * SW'(win_q[c][k]);
            rnd[c] = {1'b0, s_q[c]} + RND;
            if (!mode_q)
                conv_d[c*COLORDEPTH +: COLORDEPTH] = byp_q[c];
            else if (rnd[c][SW])
                conv_d[c*COLORDEPTH +: COLORDEPTH] = PMAX;
            else
                conv_d[c*COLORDEPTH +: COLORDEPTH] = rnd[c][SW-1:SHIFT];
        end
    end

    // NOTE: non-blocking assignments throughout so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            dv_d    <= '0;
            hs_d    <= '0;
            vs_d    <= '0;
            flush_q <= '0;
            mode_q  <= 1'b1;
            conv_q  <= '0;
            // NOTE: the window arrays are reset explicitly so a discarded line leaves no residue.
            for (int c = 0; c < CHANNELS; c++) begin
                s_q[c]   <= '0;
                byp_q[c] <= '0;
                for (int k = 0; k < M_DEPTH; k++) win_q[c][k] <= '0;
                for (int k = 0; k <= H; k++)      ctr_q[c][k] <= '0;
            end
        end else begin
            dv_d    <= {dv_d[LAT-1:1], dv_i};
            hs_d    <= {hs_d[LAT-1:1], hs_i};
            vs_d    <= {vs_d[LAT-1:1], vs_i};
            flush_q <= flush_d;
            if (vs_i && !vs_d[1]) mode_q <= mode_i;
            if (dv_d[LAT-1])      conv_q <= conv_d;
            for (int c = 0; c < CHANNELS; c++) begin
                s_q[c]   <= s_d[c];
                byp_q[c] <= ctr_q[c][H];
                if (rise) begin
                    for (int k = 0; k < M_DEPTH; k++) win_q[c][k] <= v_in[c];
                    for (int k = 0; k <= H; k++)      ctr_q[c][k] <= pix_mid[c];
                end else if (shift_en) begin
                    // During flush slot 0 keeps the last column, replicating it rightwards.
                    win_q[c][0] <= dv_i ? v_in[c] : win_q[c][0];
                    ctr_q[c][0] <= dv_i ? pix_mid[c] : ctr_q[c][0];
                    for (int k = 1; k < M_DEPTH; k++) win_q[c][k] <= win_q[c][k-1];
                    for (int k = 1; k <= H; k++)      ctr_q[c][k] <= ctr_q[c][k-1];
                end
            end
        end
    end

    assign conv_o     = conv_q;
    assign dv_o       = dv_d[LAT];
    assign hs_o       = hs_d[LAT];
    assign vs_o       = vs_d[LAT];
    assign line_end_o = dv_d[LAT] & ~dv_d[LAT-1];

`ifdef GAUSS_BLUR_NCH_SVA_EN
    if ((M_DEPTH % 2) == 0 || M_DEPTH < 3 || M_DEPTH > 9) begin : g_bad_depth
        $error("M_DEPTH must be odd and within 3..9");
    end

    logic [3:0] age_q;
    logic       armed_q, dv_o_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            age_q   <= '0;
            armed_q <= 1'b0;
            dv_o_q  <= 1'b0;
        end else begin
            if (age_q != 4'(LAT)) age_q <= age_q + 4'd1;
            dv_o_q <= dv_o;
            if (line_end_o)            armed_q <= 1'b1;
            else if (dv_o && !dv_o_q)  armed_q <= 1'b0;
        end
    end

    a_blanking: assert property (@(posedge clk) disable iff (rst)
        rise |-> (flush_q == '0));
    a_dv_delay: assert property (@(posedge clk) disable iff (rst)
        (age_q == 4'(LAT)) |-> (dv_o == $past(dv_i, LAT)));
    a_le_dv: assert property (@(posedge clk) disable iff (rst)
        line_end_o |-> dv_o);
    a_le_run: assert property (@(posedge clk) disable iff (rst)
        (line_end_o && armed_q) |-> (dv_o && !dv_o_q));
`endif

endmodule

// File: tb/tb_gauss_blur_nch.sv
// Directed bench for gauss_blur_nch at M_DEPTH=3, 8-bit, 3 channels.
module tb_gauss_blur_nch;

    localparam int CD  = 8;
    localparam int MD  = 3;
    localparam int CH  = 3;
    localparam int VIN = CH * MD * CD;
    localparam int OW  = CH * CD;

    logic           clk = 1'b0;
    logic           rst;
    logic [VIN-1:0] vect_in;
    logic           dv_i, hs_i, vs_i, mode_i;
    logic [OW-1:0]  conv_o;
    logic           dv_o, hs_o, vs_o, line_end_o;

    gauss_blur_nch #(.COLORDEPTH(CD), .M_DEPTH(MD), .CHANNELS(CH)) dut (
        .clk(clk), .rst(rst), .vect_in(vect_in), .dv_i(dv_i), .hs_i(hs_i),
        .vs_i(vs_i), .mode_i(mode_i), .conv_o(conv_o), .dv_o(dv_o),
        .hs_o(hs_o), .vs_o(vs_o), .line_end_o(line_end_o)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [OW-1:0] pix;
        logic          le;
    } exp_t;

    exp_t q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   cyc      = 0;
    bit   lat_chk  = 0;
    logic hdv [0:4095];
    logic hhs [0:4095];
    logic hvs [0:4095];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [VIN-1:0] col3(input logic [7:0] t, input logic [7:0] m, input logic [7:0] b);
        logic [VIN-1:0] v;
        v = '0;
        for (int c = 0; c < CH; c++) begin
            v[(c*MD+0)*CD +: CD] = t;
            v[(c*MD+1)*CD +: CD] = m;
            v[(c*MD+2)*CD +: CD] = b;
        end
        return v;
    endfunction

    function automatic logic [VIN-1:0] chan3(input logic [7:0] a0, input logic [7:0] a1, input logic [7:0] a2);
        logic [VIN-1:0] v;
        v = '0;
        for (int r = 0; r < MD; r++) begin
            v[(0*MD+r)*CD +: CD] = a0;
            v[(1*MD+r)*CD +: CD] = a1;
            v[(2*MD+r)*CD +: CD] = a2;
        end
        return v;
    endfunction

    function automatic logic [OW-1:0] rep(input logic [7:0] p);
        return {p, p, p};
    endfunction

    // Input history, sampled on the edge the DUT samples it.
    always @(posedge clk) begin
        hdv[cyc] = dv_i;
        hhs[cyc] = hs_i;
        hvs[cyc] = vs_i;
        cyc++;
    end

    always @(negedge clk) begin
        exp_t e;
        if (lat_chk && cyc >= 4) begin
            check("dv_lat4", dv_o, hdv[cyc-4]);
            check("hs_lat4", hs_o, hhs[cyc-4]);
            check("vs_lat4", vs_o, hvs[cyc-4]);
        end
        check("le_without_dv", line_end_o & ~dv_o, 0);
        if (dv_o) begin
            if (q.size() == 0) begin
                check("extra_dv", dv_o, 0);
            end else begin
                e = q.pop_front();
                check("conv", conv_o, e.pix);
                check("line_end", line_end_o, e.le);
            end
        end
    end

    task automatic drive(input logic dv, input logic hs, input logic vs, input logic [VIN-1:0] col);
        @(negedge clk);
        dv_i    = dv;
        hs_i    = hs;
        vs_i    = vs;
        vect_in = col;
    endtask

    task automatic px(input logic [VIN-1:0] col, input logic [OW-1:0] exp, input bit last);
        q.push_back('{pix: exp, le: last});
        drive(1'b1, 1'b0, 1'b0, col);
    endtask

    task automatic blank(input int n);
        repeat (n) drive(1'b0, 1'b0, 1'b0, '0);
    endtask

    task automatic drain();
        for (int i = 0; i < 20 && q.size() != 0; i++) @(negedge clk);
        check("drain", q.size(), 0);
    endtask

    task automatic impulse_line(input logic [7:0] e0, input logic [7:0] e1, input logic [7:0] e2);
        drive(1'b0, 1'b1, 1'b0, '0);
        px(col3(0, 0, 0),   rep(e0), 1'b0);
        px(col3(0, 255, 0), rep(e1), 1'b0);
        px(col3(0, 0, 0),   rep(e2), 1'b1);
        blank(3);
    endtask

    task automatic edge_line();
        drive(1'b0, 1'b1, 1'b0, '0);
        px(col3(0, 0, 0),    rep(8'd4),  1'b0);
        px(col3(16, 16, 16), rep(8'd16), 1'b0);
        px(col3(32, 32, 32), rep(8'd32), 1'b0);
        px(col3(48, 48, 48), rep(8'd44), 1'b1);
        blank(3);
    endtask

    task automatic flat_line(input logic [7:0] v, input int n);
        drive(1'b0, 1'b1, 1'b0, '0);
        for (int i = 0; i < n; i++) px(col3(v, v, v), rep(v), i == n - 1);
        blank(2);
    endtask

    initial begin
        rst = 1'b1; dv_i = 1'b0; hs_i = 1'b0; vs_i = 1'b0; mode_i = 1'b1; vect_in = '0;
        repeat (3) @(negedge clk);
        check("rst_conv", conv_o, 0);
        check("rst_dv", dv_o, 0);
        check("rst_hs", hs_o, 0);
        check("rst_vs", vs_o, 0);
        check("rst_le", line_end_o, 0);
        rst = 1'b0;

        // Flat field frame with timing delay checks, plus per-channel distinct levels.
        lat_chk = 1;
        drive(1'b0, 1'b0, 1'b1, '0);
        blank(1);
        flat_line(8'd100, 6);
        flat_line(8'd100, 6);
        drive(1'b0, 1'b1, 1'b0, '0);
        for (int i = 0; i < 4; i++) px(chan3(10, 20, 30), {8'd30, 8'd20, 8'd10}, i == 3);
        blank(3);
        drain();

        impulse_line(8'd32, 8'd64, 8'd32);
        edge_line();
        drain();

        // Mode change mid-frame stays blurred; next frame bypasses.
        mode_i = 1'b0;
        impulse_line(8'd32, 8'd64, 8'd32);
        drive(1'b0, 1'b0, 1'b1, '0);
        blank(1);
        impulse_line(8'd0, 8'd255, 8'd0);
        drain();
        mode_i = 1'b1;
        drive(1'b0, 1'b0, 1'b1, '0);
        blank(1);
        flat_line(8'd100, 6);
        drain();

        // Reset at pixel 2 of an aborted line.
        lat_chk = 0;
        drive(1'b0, 1'b1, 1'b0, '0);
        drive(1'b1, 1'b0, 1'b0, col3(50, 50, 50));
        drive(1'b1, 1'b0, 1'b0, col3(50, 50, 50));
        @(negedge clk);
        rst = 1'b1; dv_i = 1'b1; vect_in = col3(50, 50, 50);
        @(negedge clk);
        rst = 1'b0; dv_i = 1'b0; vect_in = '0;
        check("midrst_conv", conv_o, 0);
        check("midrst_dv", dv_o, 0);
        check("midrst_hs", hs_o, 0);
        check("midrst_vs", vs_o, 0);
        check("midrst_le", line_end_o, 0);
        blank(6);
        edge_line();
        drain();

        // Single-pixel line, two blanking cycles, then a full line.
        drive(1'b0, 1'b1, 1'b0, '0);
        px(col3(200, 200, 200), rep(8'd200), 1'b1);
        drive(1'b0, 1'b0, 1'b0, '0);
        drive(1'b0, 1'b1, 1'b0, '0);
        px(col3(0, 0, 0),    rep(8'd4),  1'b0);
        px(col3(16, 16, 16), rep(8'd16), 1'b0);
        px(col3(32, 32, 32), rep(8'd32), 1'b0);
        px(col3(48, 48, 48), rep(8'd44), 1'b1);
        blank(3);
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
